// File: rtl/comp_bin_pipe.sv
// rtl/comp_bin_pipe.sv - two-stage N-bit comparator with mode select, valid/ready handshake and result debounce filter
module comp_bin_pipe #(
    parameter  int N        = 8,
    parameter  int CONF_CNT = 4,
    localparam int CW       = $clog2(CONF_CNT + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_n,
    input  logic          i_Clear,
    input  logic          i_Valid,
    output logic          o_Ready,
    input  logic [N-1:0]  i_A,
    input  logic [N-1:0]  i_B,
    input  logic [1:0]    i_Mode,
    output logic          o_Valid,
    input  logic          i_Ready,
    output logic          o_Mayor,
    output logic          o_Igual,
    output logic          o_Menor,
    output logic          o_MayorFilt,
    output logic          o_IgualFilt,
    output logic          o_MenorFilt,
    output logic [CW-1:0] o_Cnt
);

    // Map an operand onto an N+1-bit unsigned key whose ordering matches the selected format.
    // Signed modes flip the MSB so two's-complement order becomes plain unsigned order; the
    // magnitude mode widens by one bit so the most negative value has an exact absolute value.
    function automatic logic [N:0] to_key(input logic [N-1:0] x, input logic [1:0] m);
        logic [N:0] k;
        case (m)
            2'b00:   k = {1'b0, x};
            2'b01,
            2'b10:   k = {1'b0, ~x[N-1], x[N-2:0]};
            default: k = x[N-1] ? ({1'b0, ~x} + {{N{1'b0}}, 1'b1}) : {1'b0, x};
        endcase
        return k;
    endfunction

    logic         adv;
    logic         s1_valid;
    logic [N:0]   s1_a;
    logic [N:0]   s1_b;
    logic [2:0]   rel_new;
    logic         same_rel;
    logic [CW-1:0] cnt_next;

    // Whole pipeline moves when the output slot is empty or being consumed.
    assign adv     = ~o_Valid | i_Ready;
    assign o_Ready = adv;

    // Relation of the stage-1 keys and the next confirmation count if it is loaded.
    always_comb begin
        rel_new  = {s1_a > s1_b, s1_a == s1_b, s1_a < s1_b};
        same_rel = o_Valid && (rel_new == {o_Mayor, o_Igual, o_Menor});
        cnt_next = CW'(1);
        if (same_rel) begin
            cnt_next = (o_Cnt == CW'(CONF_CNT)) ? o_Cnt : o_Cnt + CW'(1);
        end
    end

    // Stage 1: capture the mode-transformed operands.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (i_Clear) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= i_Valid;
            s1_a     <= to_key(i_A, i_Mode);
            s1_b     <= to_key(i_B, i_Mode);
        end
    end

    // Stage 2: register the one-hot relation and update the debounce filter on real results only.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Valid     <= 1'b0;
            o_Mayor     <= 1'b0;
            o_Igual     <= 1'b0;
            o_Menor     <= 1'b0;
            o_Cnt       <= '0;
            o_MayorFilt <= 1'b0;
            o_IgualFilt <= 1'b0;
            o_MenorFilt <= 1'b0;
        end else if (i_Clear) begin
            o_Valid     <= 1'b0;
            o_Cnt       <= '0;
            o_MayorFilt <= 1'b0;
            o_IgualFilt <= 1'b0;
            o_MenorFilt <= 1'b0;
        end else if (adv) begin
            o_Valid <= s1_valid;
            if (s1_valid) begin
                {o_Mayor, o_Igual, o_Menor} <= rel_new;
                o_Cnt <= cnt_next;
                {o_MayorFilt, o_IgualFilt, o_MenorFilt} <=
                    (cnt_next == CW'(CONF_CNT)) ? rel_new : 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_comp_bin_pipe.sv
// tb/tb_comp_bin_pipe.sv - scoreboard bench for comp_bin_pipe
module tb_comp_bin_pipe;

    localparam int N    = 8;
    localparam int CONF = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          iv = 1'b0;
    logic          ordy;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic [1:0]    mode = 2'b00;
    logic          ov;
    logic          ir = 1'b1;
    logic          mayor, igual, menor;
    logic          mf, igf, lf;
    logic [CW-1:0] cnt;

    typedef struct packed {
        logic [2:0]    rel;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   passes = 0;

    comp_bin_pipe #(.N(N), .CONF_CNT(CONF)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr), .i_Valid(iv), .o_Ready(ordy),
        .i_A(a), .i_B(b), .i_Mode(mode), .o_Valid(ov), .i_Ready(ir),
        .o_Mayor(mayor), .o_Igual(igual), .o_Menor(menor),
        .o_MayorFilt(mf), .o_IgualFilt(igf), .o_MenorFilt(lf), .o_Cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] rel, input logic [CW-1:0] c);
        exp_t t;
        t.rel = rel;
        t.cnt = c;
        sbq.push_back(t);
    endtask

    // Present one sample and hold it until the DUT accepts it.
    task automatic send(input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] rel, input logic [CW-1:0] c);
        int   n;
        logic ok;
        n    = 0;
        mode = m;
        a    = va;
        b    = vb;
        iv   = 1'b1;
        do begin
            #2;
            ok = ordy;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        iv = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
        else push_exp(rel, c);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain", sbq.size(), 0);
        repeat (3) step();
    endtask

    // Monitor: compare each consumed result against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov && !ir) chk("o_ready_stall", ordy, 0);
            if (ov && ir) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rel", {mayor, igual, menor}, e.rel);
                    chk("cnt", cnt, e.cnt);
                    chk("filt", {mf, igf, lf}, (e.cnt == CW'(CONF)) ? e.rel : 3'b000);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        chk("rst_valid", ov, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_filt", {mf, igf, lf}, 0);
        chk("rst_ready", ordy, 1);
        rst_n = 1'b1;
        step();

        // Latency: accepted at one edge, result visible after the second edge.
        mode = 2'b00; a = 8'h80; b = 8'h7F; iv = 1'b1;
        chk("lat_ready", ordy, 1);
        step();
        iv = 1'b0;
        push_exp(3'b100, 1);
        chk("lat_c1", ov, 0);
        step();
        chk("lat_c2", ov, 1);
        drain();

        send(2'b10, 8'h80, 8'h7F, 3'b001, 1);
        drain();

        // Mode switching inside one stream.
        send(2'b01, 8'h80, 8'h7F, 3'b001, 1);
        send(2'b11, 8'h80, 8'h7F, 3'b100, 1);
        send(2'b11, 8'hFF, 8'h01, 3'b010, 1);
        send(2'b10, 8'h00, 8'h00, 3'b010, 2);
        drain();

        // Filter build-up, saturation, and restart on a new relation.
        send(2'b00, 8'h05, 8'h03, 3'b100, 1);
        send(2'b00, 8'hFF, 8'h00, 3'b100, 2);
        send(2'b00, 8'h01, 8'h00, 3'b100, 3);
        send(2'b10, 8'h7F, 8'h80, 3'b100, 4);
        send(2'b00, 8'h10, 8'h0F, 3'b100, 4);
        send(2'b00, 8'h33, 8'h33, 3'b010, 1);
        drain();

        // Backpressure in the middle of a six-sample stream.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(2'b00, 8'(10 + i), 8'h05, 3'b100, CW'((i < 3) ? i + 1 : 4));
            end
            begin
                ir = 1'b1;
                repeat (2) step();
                ir = 1'b0;
                repeat (3) step();
                ir = 1'b1;
            end
        join
        drain();

        // Asynchronous reset while a result is held.
        send(2'b00, 8'h09, 8'h01, 3'b100, 1);
        send(2'b00, 8'h08, 8'h01, 3'b100, 2);
        send(2'b00, 8'h07, 8'h01, 3'b100, 3);
        step();
        ir = 1'b0;
        #1;
        chk("pre_rst_valid", ov, 1);
        chk("pre_rst_cnt", cnt, 3);
        chk("pre_rst_ready", ordy, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", ov, 0);
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_flags", {mayor, igual, menor}, 0);
        chk("async_rst_filt", {mf, igf, lf}, 0);
        chk("async_rst_ready", ordy, 1);
        sbq.delete();
        repeat (2) step();
        rst_n = 1'b1;
        ir = 1'b1;
        step();
        send(2'b00, 8'h02, 8'h01, 3'b100, 1);
        drain();

        // Synchronous clear with a sample offered in the same cycle.
        send(2'b00, 8'h09, 8'h01, 3'b100, 1);
        send(2'b00, 8'h08, 8'h01, 3'b100, 2);
        send(2'b00, 8'h07, 8'h01, 3'b100, 3);
        step();
        ir = 1'b0;
        #1;
        chk("pre_clr_cnt", cnt, 3);
        @(posedge clk);
        #1;
        ir = 1'b1; clr = 1'b1; iv = 1'b1; mode = 2'b00; a = 8'h09; b = 8'h09;
        step();
        clr = 1'b0; iv = 1'b0;
        chk("clr_valid", ov, 0);
        chk("clr_cnt", cnt, 0);
        chk("clr_filt", {mf, igf, lf}, 0);
        step();
        chk("clr_discard", ov, 0);
        chk("clr_queue", sbq.size(), 0);
        send(2'b00, 8'h01, 8'h02, 3'b001, 1);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
